// File: rtl/cpu_pkg.sv
// Shared constants and types for the cpu_pipe core: opcodes, funct fields, ALU op and
// writeback-select encodings.
package cpu_pkg;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SR   = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   localparam logic [2:0] F3_CSRRW = 3'b001;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   localparam logic [31:0] NOP              = 32'h0000_0013;
   localparam logic [11:0] CSR_BASE_DEFAULT = 12'hF00;

   typedef enum logic [3:0] {
      AluAdd, AluSub, AluSll, AluSlt, AluSltu, AluXor, AluSrl, AluSra, AluOr, AluAnd
   } aluop_t;

   typedef enum logic [1:0] {WbAlu, WbImmU, WbGpio, WbLink} wbsel_t;

   // alt selects SUB/SRA; callers only raise it where funct7 is meaningful.
   function automatic aluop_t alu_decode(input logic [2:0] f3, input logic alt);
      aluop_t op;
      case (f3)
         F3_ADD:  op = alt ? AluSub : AluAdd;
         F3_SLL:  op = AluSll;
         F3_SLT:  op = AluSlt;
         F3_SLTU: op = AluSltu;
         F3_XOR:  op = AluXor;
         F3_SR:   op = alt ? AluSra : AluSrl;
         F3_OR:   op = AluOr;
         default: op = AluAnd;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/alu.sv
// 32-bit integer ALU, purely combinational.
module alu
   import cpu_pkg::*;
(
   input  aluop_t      op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] y
);

   always_comb begin
      y = '0;
      case (op)
         AluAdd:  y = a + b;
         AluSub:  y = a - b;
         AluSll:  y = a << b[4:0];
         AluSlt:  y = {31'b0, $signed(a) < $signed(b)};
         AluSltu: y = {31'b0, a < b};
         AluXor:  y = a ^ b;
         AluSrl:  y = a >> b[4:0];
         AluSra:  y = $signed(a) >>> b[4:0];
         AluOr:   y = a | b;
         AluAnd:  y = a & b;
         default: y = '0;
      endcase
   end

endmodule

// File: rtl/cpu_branch_unit.sv
// Branch condition evaluation and word-addressed target computation for the EX stage.
module cpu_branch_unit
   import cpu_pkg::*;
#(
   parameter int unsigned IMEM_AW = 12
) (
   input  logic               is_branch,
   input  logic               is_jal,
   input  logic [2:0]         funct3,
   input  logic [31:0]        rs1_val,
   input  logic [31:0]        rs2_val,
   input  logic [31:0]        imm,
   input  logic [IMEM_AW-1:0] pc,
   output logic               taken,
   output logic [IMEM_AW-1:0] target
);

   logic        eq, lt, ltu, cond;
   logic [31:0] woff;
   logic        unused_woff;

   assign eq  = rs1_val == rs2_val;
   assign lt  = $signed(rs1_val) < $signed(rs2_val);
   assign ltu = rs1_val < rs2_val;

   always_comb begin
      cond = 1'b0;
      case (funct3)
         F3_BEQ:  cond = eq;
         F3_BNE:  cond = !eq;
         F3_BLT:  cond = lt;
         F3_BGE:  cond = !lt;
         F3_BLTU: cond = ltu;
         F3_BGEU: cond = !ltu;
         default: cond = 1'b0;
      endcase
   end

   // Byte offset to word offset; bit 1 simply falls off.
   assign woff        = $signed(imm) >>> 2;
   assign unused_woff = ^woff;
   assign taken       = is_jal || (is_branch && cond);
   assign target      = pc + woff[IMEM_AW-1:0];

endmodule

// File: rtl/regfile.sv
// 31x32 register file with x0 hard-wired to zero; two async read ports, one write port.
module regfile (
   input  logic        clk,
   input  logic        we,
   input  logic [4:0]  waddr,
   input  logic [31:0] wdata,
   input  logic [4:0]  raddr1,
   input  logic [4:0]  raddr2,
   output logic [31:0] rdata1,
   output logic [31:0] rdata2
);

   logic [31:0] regs [1:31];

   always_ff @(posedge clk) begin
      if (we && waddr != 5'd0) regs[waddr] <= wdata;
   end

   assign rdata1 = (raddr1 == 5'd0) ? '0 : regs[raddr1];
   assign rdata2 = (raddr2 == 5'd0) ? '0 : regs[raddr2];

endmodule

// File: rtl/cpu_pipe.sv
// Three-slot (Fetch/Execute/Writeback) RV32I-subset core with GPIO channels in CSR space.
// Optional macro CPU_PERF_EN adds the retired_cnt instruction counter output.
module cpu_pipe
   import cpu_pkg::*;
#(
   parameter int unsigned        IMEM_AW  = 12,
   parameter int unsigned        GPIO_CH  = 2,
   parameter int unsigned        GPIO_W   = 32,
   parameter logic [IMEM_AW-1:0] RESET_PC = '0,
   parameter logic [11:0]        CSR_BASE = CSR_BASE_DEFAULT
) (
   input  logic                      clk,
   input  logic                      rst,
   output logic [IMEM_AW-1:0]        imem_addr,
   input  logic [31:0]               imem_rdata,
   input  logic [GPIO_CH*GPIO_W-1:0] gpio_in,
   output logic [GPIO_CH*GPIO_W-1:0] gpio_out,
   output logic                      halted
`ifdef CPU_PERF_EN
   ,
   output logic [31:0]               retired_cnt
`endif
);

   logic [IMEM_AW-1:0] pc_q, pc_ex_q;
   logic               ex_valid_q, halted_q;

   logic               wb_valid_q, wb_rf_we_q, wb_gpio_we_q;
   logic [4:0]         wb_rd_q;
   logic [31:0]        wb_data_q;
   logic [3:0]         wb_gpio_ch_q;
   logic [GPIO_W-1:0]  wb_gpio_data_q;
   logic [GPIO_CH*GPIO_W-1:0] gpio_q;

   logic [31:0] instr;
   logic [6:0]  opcode, funct7;
   logic [2:0]  funct3;
   logic [4:0]  rd, rs1, rs2;
   logic [31:0] imm_i, imm_u, imm_b, imm_j;
   logic [11:0] csr_off;
   logic        csr_hit;
   logic [3:0]  csr_idx;

   logic        dec_legal, dec_rf_we, dec_gpio_we, dec_branch, dec_jal, dec_use_imm;
   aluop_t      dec_alu_op;
   wbsel_t      dec_wbsel;

   logic [31:0] rf_rdata1, rf_rdata2, rs1_val, rs2_val, alu_b, alu_y;
   logic [31:0] gpio_rd, link, wb_res;
   logic [IMEM_AW-1:0] pc_ex_inc, br_target;
   logic        br_taken, ex_fire, illegal, redirect;

   assign instr   = imem_rdata;
   assign opcode  = instr[6:0];
   assign rd      = instr[11:7];
   assign funct3  = instr[14:12];
   assign rs1     = instr[19:15];
   assign rs2     = instr[24:20];
   assign funct7  = instr[31:25];
   assign imm_i   = {{20{instr[31]}}, instr[31:20]};
   assign imm_u   = {instr[31:12], 12'b0};
   assign imm_b   = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
   assign imm_j   = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

   assign csr_off = instr[31:20] - CSR_BASE;
   assign csr_hit = (instr[31:20] >= CSR_BASE) && ({20'b0, csr_off} < GPIO_CH);
   assign csr_idx = csr_off[3:0];

   always_comb begin
      dec_legal   = 1'b0;
      dec_rf_we   = 1'b0;
      dec_gpio_we = 1'b0;
      dec_branch  = 1'b0;
      dec_jal     = 1'b0;
      dec_use_imm = 1'b0;
      dec_alu_op  = AluAdd;
      dec_wbsel   = WbAlu;
      case (opcode)
         OPC_LUI: begin
            dec_legal = 1'b1;
            dec_rf_we = 1'b1;
            dec_wbsel = WbImmU;
         end
         OPC_OP_IMM: begin
            dec_rf_we   = 1'b1;
            dec_use_imm = 1'b1;
            dec_alu_op  = alu_decode(funct3, funct3 == F3_SR && funct7[5]);
            if (funct3 == F3_SLL)     dec_legal = funct7 == F7_BASE;
            else if (funct3 == F3_SR) dec_legal = funct7 == F7_BASE || funct7 == F7_ALT;
            else                      dec_legal = 1'b1;
         end
         OPC_OP: begin
            dec_rf_we  = 1'b1;
            dec_alu_op = alu_decode(funct3, funct7[5]);
            dec_legal  = funct7 == F7_BASE ||
                         (funct7 == F7_ALT && (funct3 == F3_ADD || funct3 == F3_SR));
         end
         OPC_BRANCH: begin
            dec_branch = 1'b1;
            dec_legal  = funct3 != F3_SLT && funct3 != F3_SLTU;
         end
         OPC_JAL: begin
            dec_legal = 1'b1;
            dec_jal   = 1'b1;
            dec_rf_we = 1'b1;
            dec_wbsel = WbLink;
         end
         OPC_SYSTEM: begin
            if (funct3 == F3_CSRRW && csr_hit) begin
               dec_legal   = 1'b1;
               dec_rf_we   = 1'b1;
               dec_gpio_we = 1'b1;
               dec_wbsel   = WbGpio;
            end
         end
         default: dec_legal = 1'b0;
      endcase
   end

   regfile u_regfile (
      .clk    (clk),
      .we     (wb_valid_q && wb_rf_we_q),
      .waddr  (wb_rd_q),
      .wdata  (wb_data_q),
      .raddr1 (rs1),
      .raddr2 (rs2),
      .rdata1 (rf_rdata1),
      .rdata2 (rf_rdata2)
   );

   // WB result bypasses the register file, which is only written at the end of the WB cycle.
   always_comb begin
      rs1_val = rf_rdata1;
      rs2_val = rf_rdata2;
      if (wb_valid_q && wb_rf_we_q && wb_rd_q != 5'd0) begin
         if (wb_rd_q == rs1) rs1_val = wb_data_q;
         if (wb_rd_q == rs2) rs2_val = wb_data_q;
      end
   end

   assign alu_b = dec_use_imm ? imm_i : rs2_val;

   alu u_alu (
      .op (dec_alu_op),
      .a  (rs1_val),
      .b  (alu_b),
      .y  (alu_y)
   );

   cpu_branch_unit #(
      .IMEM_AW (IMEM_AW)
   ) u_branch (
      .is_branch (dec_branch),
      .is_jal    (dec_jal),
      .funct3    (funct3),
      .rs1_val   (rs1_val),
      .rs2_val   (rs2_val),
      .imm       (dec_jal ? imm_j : imm_b),
      .pc        (pc_ex_q),
      .taken     (br_taken),
      .target    (br_target)
   );

   always_comb begin
      gpio_rd = '0;
      for (int unsigned k = 0; k < GPIO_CH; k++) begin
         if ({28'b0, csr_idx} == k) gpio_rd[GPIO_W-1:0] = gpio_in[k*GPIO_W +: GPIO_W];
      end
   end

   assign pc_ex_inc = pc_ex_q + IMEM_AW'(1);

   always_comb begin
      link = '0;
      link[IMEM_AW-1:0] = pc_ex_inc;
      link = link << 2;
   end

   always_comb begin
      wb_res = '0;
      case (dec_wbsel)
         WbAlu:   wb_res = alu_y;
         WbImmU:  wb_res = imm_u;
         WbGpio:  wb_res = gpio_rd;
         WbLink:  wb_res = link;
         default: wb_res = '0;
      endcase
   end

   assign ex_fire  = ex_valid_q && !halted_q;
   assign illegal  = ex_fire && !dec_legal;
   assign redirect = ex_fire && dec_legal && br_taken;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q       <= RESET_PC;
         pc_ex_q    <= RESET_PC;
         ex_valid_q <= 1'b0;
         halted_q   <= 1'b0;
      end else if (!halted_q) begin
         if (illegal) begin
            halted_q   <= 1'b1;
            ex_valid_q <= 1'b0;
         end else begin
            pc_q       <= redirect ? br_target : pc_q + IMEM_AW'(1);
            pc_ex_q    <= pc_q;
            ex_valid_q <= !redirect;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wb_valid_q     <= 1'b0;
         wb_rf_we_q     <= 1'b0;
         wb_gpio_we_q   <= 1'b0;
         wb_rd_q        <= '0;
         wb_data_q      <= '0;
         wb_gpio_ch_q   <= '0;
         wb_gpio_data_q <= '0;
      end else begin
         wb_valid_q     <= ex_fire && dec_legal;
         wb_rf_we_q     <= dec_rf_we;
         wb_gpio_we_q   <= dec_gpio_we;
         wb_rd_q        <= rd;
         wb_data_q      <= wb_res;
         wb_gpio_ch_q   <= csr_idx;
         wb_gpio_data_q <= rs1_val[GPIO_W-1:0];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gpio_q <= '0;
      end else if (wb_valid_q && wb_gpio_we_q) begin
         for (int unsigned k = 0; k < GPIO_CH; k++) begin
            if ({28'b0, wb_gpio_ch_q} == k) gpio_q[k*GPIO_W +: GPIO_W] <= wb_gpio_data_q;
         end
      end
   end

`ifdef CPU_PERF_EN
   logic [31:0] retired_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)             retired_q <= '0;
      else if (wb_valid_q) retired_q <= retired_q + 32'd1;
   end

   assign retired_cnt = retired_q;
`endif

   assign imem_addr = pc_q;
   assign gpio_out  = gpio_q;
   assign halted    = halted_q;

endmodule
